// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad one column at a time and debounces
// both the press and the release of a single key. The accepted key is held
// as one-hot row/column codes for keypad_decoder, and a one-cycle strobe
// marks each new press.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotate the column drive, sample rows at the end of each dwell
// PRESS_DB | column frozen, candidate row must stay set to be accepted
// HELD     | key accepted, waiting for its row to drop
// REL_DB   | row dropped, must stay clear before scanning resumes
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES     = 4,   // >= 3 so the synchronizer settles per column
    parameter int unsigned DEBOUNCE_CYCLES = 8    // >= 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_raw,
    output logic [3:0] cols,
    output logic [3:0] key_rows,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_HELD,
        ST_REL_DB
    } state_t;

    localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0]       sync1_q;
    logic [3:0]       rows_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] deb_q;
    logic [3:0]       r_q;
    logic [3:0]       cols_q;
    logic [3:0]       key_rows_q;
    logic [3:0]       key_col_q;
    logic             key_valid_q;
    logic             key_held_q;

    logic [3:0]       row_pick_d;
    logic             row_hit_d;

    // Two-flop synchronizer for the asynchronous row sense lines.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 4'b0000;
            rows_s_q <= 4'b0000;
        end else begin
            sync1_q  <= rows_raw;
            rows_s_q <= sync1_q;
        end
    end

    // Lowest-index active row wins; x & -x isolates the lowest set bit.
    always_comb begin
        row_pick_d = rows_s_q & (~rows_s_q + 4'd1);
        row_hit_d  = (rows_s_q & r_q) != 4'b0000;
    end

    // Scan / debounce state machine with registered outputs. The column drive
    // stays frozen from detection until the release is confirmed, so cols_q
    // doubles as the latched column of the candidate key.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            deb_q       <= '0;
            r_q         <= 4'b0000;
            cols_q      <= 4'b0001;
            key_rows_q  <= 4'b0000;
            key_col_q   <= 4'b0000;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (rows_s_q == 4'b0000) begin
                            cols_q <= {cols_q[2:0], cols_q[3]};
                        end else begin
                            r_q     <= row_pick_d;
                            deb_q   <= '0;
                            state_q <= ST_PRESS_DB;
                        end
                    end else begin
                        dwell_q <= dwell_q + CNT_ONE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!row_hit_d) begin
                        state_q <= ST_SCAN;
                        dwell_q <= '0;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q     <= ST_HELD;
                        deb_q       <= '0;
                        key_rows_q  <= r_q;
                        key_col_q   <= cols_q;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                    end else begin
                        deb_q <= deb_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!row_hit_d) begin
                        state_q <= ST_REL_DB;
                        deb_q   <= '0;
                    end
                end
                ST_REL_DB: begin
                    if (row_hit_d) begin
                        state_q <= ST_HELD;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q    <= ST_SCAN;
                        deb_q      <= '0;
                        dwell_q    <= '0;
                        key_held_q <= 1'b0;
                        cols_q     <= {cols_q[2:0], cols_q[3]};
                    end else begin
                        deb_q <= deb_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                    dwell_q <= '0;
                    deb_q   <= '0;
                end
            endcase
        end
    end

    assign cols      = cols_q;
    assign key_rows  = key_rows_q;
    assign key_col   = key_col_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes the row lines through the
// driven column; expectations come from scan timing arithmetic and simple
// rules (lowest pressed row, one strobe per press, next column after release).
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows_raw;
    logic [3:0] cols;
    logic [3:0] key_rows;
    logic [3:0] key_col;
    logic       key_valid;
    logic       key_held;

    // Keypad model: rows pressed in one column, with an open-circuit override.
    logic [3:0] kp_rows = 4'b0000;
    logic [3:0] kp_col  = 4'b0000;
    logic       kp_open = 1'b0;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    assign rows_raw = (!kp_open && ((cols & kp_col) != 4'b0000)) ? kp_rows : 4'b0000;

    keypad_scanner #(
        .SCAN_CYCLES(SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows_raw(rows_raw),
        .cols(cols),
        .key_rows(key_rows),
        .key_col(key_col),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All time advances here; strobes are counted at the sampling edge.
    task automatic tick();
        @(negedge clk);
        if (key_valid === 1'b1) vcount++;
    endtask

    function automatic logic [3:0] lowest_row(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << (c % 4));
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic press_and_check(input logic [3:0] rm, input int c, input string tag);
        int  v0;
        bit  ok;
        v0 = vcount;
        ok = 1'b0;
        kp_rows = rm;
        kp_col  = onehot(c);
        for (int k = 0; k < 150 && !ok; k++) begin
            tick();
            if (vcount != v0) ok = 1'b1;
        end
        chk({tag, "_valid_seen"}, ok, 1'b1);
        repeat (30) tick();
        chk({tag, "_one_strobe"}, vcount - v0, 1);
        chk({tag, "_rows"}, key_rows, lowest_row(rm));
        chk({tag, "_col"}, key_col, onehot(c));
        chk({tag, "_held"}, key_held, 1'b1);
        chk({tag, "_cols_frozen"}, cols, onehot(c));
    endtask

    task automatic glitch(input int g, input string tag);
        int v0;
        v0 = vcount;
        kp_open = 1'b1;
        repeat (g) tick();
        kp_open = 1'b0;
        repeat (20) tick();
        chk({tag, "_held"}, key_held, 1'b1);
        chk({tag, "_no_strobe"}, vcount - v0, 0);
    endtask

    task automatic release_and_check(input logic [3:0] rm, input int c, input string tag);
        int v0;
        bit ok;
        v0 = vcount;
        ok = 1'b0;
        kp_rows = 4'b0000;
        for (int k = 0; k < 60 && !ok; k++) begin
            tick();
            if (key_held === 1'b0) ok = 1'b1;
        end
        chk({tag, "_released"}, ok, 1'b1);
        chk({tag, "_next_col"}, cols, onehot(c + 1));
        chk({tag, "_rows_kept"}, key_rows, lowest_row(rm));
        chk({tag, "_col_kept"}, key_col, onehot(c));
        chk({tag, "_no_strobe"}, vcount - v0, 0);
    endtask

    task automatic bounce(input int n, input string tag);
        int         v0;
        bit         changed;
        logic [3:0] first;
        v0 = vcount;
        kp_rows = lowest_row(4'($urandom_range(1, 15)));
        kp_col  = onehot($urandom_range(0, 3));
        repeat (n) tick();
        kp_rows = 4'b0000;
        repeat (20) tick();
        chk({tag, "_no_strobe"}, vcount - v0, 0);
        chk({tag, "_not_held"}, key_held, 1'b0);
        first   = cols;
        changed = 1'b0;
        repeat (2 * SCAN) begin
            tick();
            if (cols !== first) changed = 1'b1;
        end
        chk({tag, "_scan_resumes"}, changed, 1'b1);
    endtask

    // Key pressed through reset: column c is sampled at edge 4c+3 after reset
    // release, and the strobe follows DEB edges later.
    task automatic press_from_reset(input logic [3:0] rm, input int c, input string tag);
        int v0;
        int exp_k;
        kp_rows = rm;
        kp_col  = onehot(c);
        kp_open = 1'b0;
        do_reset();
        v0    = vcount;
        exp_k = SCAN * c + (SCAN - 1) + DEB;
        for (int k = 0; k <= exp_k + 3; k++) begin
            tick();
            chk({tag, "_latency"}, key_valid, (k == exp_k));
        end
        repeat (100) tick();
        chk({tag, "_one_strobe"}, vcount - v0, 1);
        chk({tag, "_rows"}, key_rows, lowest_row(rm));
        chk({tag, "_col"}, key_col, onehot(c));
        chk({tag, "_held"}, key_held, 1'b1);
        chk({tag, "_cols_frozen"}, cols, onehot(c));
    endtask

    initial begin
        int         c;
        logic [3:0] rm;
        int         v0;
        bit         ok;

        // Reset state and idle scanning.
        do_reset();
        chk("rst_cols", cols, 4'b0001);
        chk("rst_key_rows", key_rows, 4'b0000);
        chk("rst_key_col", key_col, 4'b0000);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("idle_cols", cols, onehot((k + 1) / SCAN));
        end
        chk("idle_no_strobe", vcount, 0);
        chk("idle_held", key_held, 1'b0);
        chk("idle_key_rows", key_rows, 4'b0000);

        // Row1/col2 pressed, exact latency, then a random key the same way.
        press_from_reset(4'b0010, 2, "r1c2");
        release_and_check(4'b0010, 2, "r1c2_rel");
        c  = $urandom_range(0, 3);
        rm = 4'($urandom_range(1, 15));
        press_from_reset(rm, c, "rnd_rst");
        release_and_check(rm, c, "rnd_rst_rel");

        // Short bounce, then a stable row3/col0 press.
        bounce(5, "bounce");
        press_and_check(4'b1000, 0, "r3c0");
        release_and_check(4'b1000, 0, "r3c0_rel");

        // Two rows in column 1: lowest row wins; glitch then full release.
        press_and_check(4'b1010, 1, "dual");
        glitch(3, "glitch");
        release_and_check(4'b1010, 1, "dual_rel");

        // Randomized press / glitch / release rounds.
        for (int it = 0; it < 6; it++) begin
            bounce($urandom_range(1, 6), "rbounce");
            c  = $urandom_range(0, 3);
            rm = 4'($urandom_range(1, 15));
            press_and_check(rm, c, "rpress");
            glitch($urandom_range(1, 7), "rglitch");
            release_and_check(rm, c, "rrel");
        end

        // Reset while held: outputs clear, key re-detected once.
        c  = $urandom_range(0, 3);
        rm = 4'($urandom_range(1, 15));
        press_and_check(rm, c, "pre_rst");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_cols", cols, 4'b0001);
        chk("midrst_rows", key_rows, 4'b0000);
        chk("midrst_col", key_col, 4'b0000);
        chk("midrst_held", key_held, 1'b0);
        chk("midrst_valid", key_valid, 1'b0);
        v0 = vcount;
        ok = 1'b0;
        for (int k = 0; k < 150 && !ok; k++) begin
            tick();
            if (vcount != v0) ok = 1'b1;
        end
        chk("redetect_seen", ok, 1'b1);
        repeat (30) tick();
        chk("redetect_one", vcount - v0, 1);
        chk("redetect_rows", key_rows, lowest_row(rm));
        chk("redetect_col", key_col, onehot(c));
        release_and_check(rm, c, "post_rst_rel");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
